// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register countdown scoreboard plus branch-resolve FSM.
// Optional EX/MEM forwarding mode is enabled by defining HAZARD_FORWARD_EN.
module hazard_scoreboard #(
    parameter int unsigned NREGS        = 32,
    parameter int unsigned REGBITS      = 5,
    parameter int unsigned NSTAGES      = 3,
    parameter int unsigned BRANCH_DELAY = 2,
    parameter int unsigned LOAD_LAT     = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               issue_valid,
    input  logic [REGBITS-1:0] rs,
    input  logic [REGBITS-1:0] rt,
    input  logic               rs_used,
    input  logic               rt_used,
    input  logic               wr_en,
    input  logic [REGBITS-1:0] wr_reg,
    input  logic               wr_is_load,
    input  logic               branch,
    input  logic               dmem_wait,
    input  logic               imem_wait,
    output logic               PCWrite,
    output logic               IFIDWrite,
    output logic               Hazard,
    output logic               pipe_en,
    output logic               imem_en
);

    localparam int unsigned MaxLat = (NSTAGES > LOAD_LAT) ? NSTAGES : LOAD_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);
    localparam int unsigned BcW    = $clog2(BRANCH_DELAY + 1);

    typedef enum logic [0:0] {StIdle, StBrWait} state_e;

    state_e          state_q;
    logic [BcW-1:0]  bcnt_q;
    logic [CntW-1:0] cnt_q [NREGS];
    logic [CntW-1:0] cnt_d [NREGS];

    logic [NREGS-1:0] busy;
    logic             data_hz, adv, accept, wr_track, br_wait, br_last;
    logic [CntW-1:0]  load_val;

`ifdef HAZARD_FORWARD_EN
    assign wr_track = wr_en & wr_is_load;
    assign load_val = CntW'(LOAD_LAT);
`else
    logic unused_wr_is_load;
    assign unused_wr_is_load = wr_is_load;
    assign wr_track = wr_en;
    // A count holds the stall cycles still owed to a back-to-back consumer; the result is
    // readable NSTAGES cycles after acceptance, so the immediate successor waits NSTAGES-1.
    assign load_val = CntW'(NSTAGES - 1);
`endif

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
        busy[0] = 1'b0;
    end

    assign data_hz = issue_valid & ((rs_used & busy[rs]) | (rt_used & busy[rt]));
    assign adv     = enable & ~dmem_wait & ~imem_wait;
    assign br_wait = (state_q == StBrWait);
    assign br_last = br_wait & (bcnt_q == BcW'(1));
    assign accept  = adv & issue_valid & ~data_hz & ~br_wait;

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept && wr_track && (wr_reg != '0) && (REGBITS'(i) == wr_reg)) begin
                cnt_d[i] = load_val;
            end else if (adv && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            bcnt_q  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            unique case (state_q)
                StIdle: begin
                    if (accept && branch) begin
                        state_q <= StBrWait;
                        bcnt_q  <= BcW'(BRANCH_DELAY);
                    end
                end
                StBrWait: begin
                    if (adv) begin
                        if (bcnt_q == BcW'(1)) begin
                            state_q <= StIdle;
                        end
                        bcnt_q <= bcnt_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        Hazard    = 1'b0;
        pipe_en   = 1'b0;
        imem_en   = 1'b0;
        if (!reset) begin
            Hazard = 1'b0;
        end else if (!enable) begin
            Hazard = data_hz | br_wait;
        end else if (dmem_wait || imem_wait) begin
            Hazard  = data_hz | br_wait;
            imem_en = ~dmem_wait;
        end else if (br_wait) begin
            // Final wait cycle fetches the resolved path early.
            Hazard  = 1'b1;
            pipe_en = 1'b1;
            PCWrite = br_last;
            imem_en = br_last;
        end else if (data_hz) begin
            Hazard  = 1'b1;
            pipe_en = 1'b1;
        end else begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
            pipe_en   = 1'b1;
            imem_en   = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic
// checked against a cycle-count model of register readiness and branch resolution.
module tb_hazard_scoreboard;

    localparam int unsigned NREGS        = 32;
    localparam int unsigned REGBITS      = 5;
    localparam int unsigned NSTAGES      = 3;
    localparam int unsigned BRANCH_DELAY = 2;
    localparam int unsigned LOAD_LAT     = 1;

`ifdef HAZARD_FORWARD_EN
    localparam int ALU_STALL  = 0;
    localparam int LOAD_STALL = LOAD_LAT;
`else
    localparam int ALU_STALL  = NSTAGES - 1;
    localparam int LOAD_STALL = NSTAGES - 1;
`endif

    logic clock, reset, enable, issue_valid, rs_used, rt_used, wr_en, wr_is_load, branch;
    logic dmem_wait, imem_wait;
    logic [REGBITS-1:0] rs, rt, wr_reg;
    logic PCWrite, IFIDWrite, Hazard, pipe_en, imem_en;
    logic [4:0] outs;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a_cnt counts advancing cycles; a register is readable once a_cnt reaches
    // ready_at[r]; the branch wait covers advancing cycles up to and including br_end.
    longint a_cnt;
    longint ready_at [NREGS];
    longint br_end;

    hazard_scoreboard #(
        .NREGS(NREGS), .REGBITS(REGBITS), .NSTAGES(NSTAGES),
        .BRANCH_DELAY(BRANCH_DELAY), .LOAD_LAT(LOAD_LAT)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .issue_valid(issue_valid),
        .rs(rs), .rt(rt), .rs_used(rs_used), .rt_used(rt_used), .wr_en(wr_en),
        .wr_reg(wr_reg), .wr_is_load(wr_is_load), .branch(branch),
        .dmem_wait(dmem_wait), .imem_wait(imem_wait), .PCWrite(PCWrite),
        .IFIDWrite(IFIDWrite), .Hazard(Hazard), .pipe_en(pipe_en), .imem_en(imem_en)
    );

    assign outs = {PCWrite, IFIDWrite, Hazard, pipe_en, imem_en};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic m_busy(input logic [REGBITS-1:0] r);
        return (r != '0) && (a_cnt < ready_at[r]);
    endfunction

    function automatic logic m_dhz();
        return issue_valid && ((rs_used && m_busy(rs)) || (rt_used && m_busy(rt)));
    endfunction

    function automatic logic [4:0] m_out();
        logic in_br, last, hz;
        in_br = (a_cnt <= br_end);
        last  = (a_cnt == br_end);
        hz    = m_dhz();
        if (!reset) return 5'b00000;
        if (!enable) return {2'b00, hz | in_br, 2'b00};
        if (dmem_wait || imem_wait) return {2'b00, hz | in_br, 1'b0, ~dmem_wait};
        if (in_br) return {last, 1'b0, 1'b1, 1'b1, last};
        if (hz) return 5'b00110;
        return 5'b11011;
    endfunction

    task automatic m_step();
        logic adv, acc;
        if (!reset) begin
            a_cnt = 0;
            foreach (ready_at[i]) ready_at[i] = 0;
            br_end = -1;
        end else begin
            adv = enable && !dmem_wait && !imem_wait;
            acc = adv && issue_valid && !m_dhz() && !(a_cnt <= br_end);
            if (acc && wr_en && wr_reg != '0) begin
`ifdef HAZARD_FORWARD_EN
                if (wr_is_load) ready_at[wr_reg] = a_cnt + 1 + LOAD_LAT;
`else
                ready_at[wr_reg] = a_cnt + NSTAGES;
`endif
            end
            if (acc && branch) br_end = a_cnt + BRANCH_DELAY;
            if (adv) a_cnt++;
        end
    endtask

    task automatic set_in(input logic iv, input logic [4:0] s, input logic [4:0] t,
                          input logic su, input logic tu, input logic we,
                          input logic [4:0] w, input logic ld, input logic br);
        issue_valid = iv; rs = s; rt = t; rs_used = su; rt_used = tu;
        wr_en = we; wr_reg = w; wr_is_load = ld; branch = br;
    endtask

    task automatic advance();
        m_step();
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) begin
            #1;
            advance();
        end
    endtask

    // Presents a reader of r until it is accepted; returns stall cycles (99 if it never is).
    task automatic count_stalls(input logic [4:0] r, output int n);
        logic done;
        done = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            set_in(1, r, 0, 1, 0, 0, 0, 0, 0);
            #1;
            if (Hazard) n++;
            else done = 1'b1;
            advance();
        end
        if (!done) n = 99;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; dmem_wait = 1'b0; imem_wait = 1'b0;
        set_in(1, 1, 2, 1, 1, 1, 3, 0, 0);
        repeat (2) begin
            #1; n_tests++;
            if (outs !== 5'b00000) begin
                n_fail++; $display("FAIL reset_outs: got %b expected %b", outs, 5'b00000);
            end
            advance();
        end
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1; n_tests++;
        if (outs !== 5'b11011) begin
            n_fail++; $display("FAIL post_reset_idle: got %b expected %b", outs, 5'b11011);
        end
        advance();
        set_in(1, 0, 0, 0, 0, 1, 5, 1, 1);
        #1;
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1; n_tests++;
        if (outs !== 5'b00110) begin
            n_fail++; $display("FAIL br_wait_entered: got %b expected %b", outs, 5'b00110);
        end
        advance();
        reset = 1'b0;
        repeat (3) begin
            #1; n_tests++;
            if (outs !== 5'b00000) begin
                n_fail++; $display("FAIL reset_mid_branch: got %b expected %b", outs, 5'b00000);
            end
            advance();
        end
        reset = 1'b1;
        set_in(1, 5, 0, 1, 0, 0, 0, 0, 0);
        #1; n_tests++;
        if (outs !== 5'b11011) begin
            n_fail++; $display("FAIL after_release: got %b expected %b", outs, 5'b11011);
        end
        advance();
    endtask

    task automatic test_data_hazard();
        int n;
        idle(4);
        set_in(1, 0, 0, 0, 0, 1, 5, 0, 0);
        #1; n_tests++;
        if (outs !== m_out()) begin
            n_fail++; $display("FAIL alu_producer: got %b expected %b", outs, m_out());
        end
        advance();
        count_stalls(5, n);
        n_tests++;
        if (n != ALU_STALL) begin
            n_fail++; $display("FAIL alu_use_stalls: got %0d expected %0d", n, ALU_STALL);
        end
        idle(4);
        set_in(1, 0, 0, 0, 0, 1, 3, 1, 0);
        #1;
        advance();
        count_stalls(3, n);
        n_tests++;
        if (n != LOAD_STALL) begin
            n_fail++; $display("FAIL load_use_stalls: got %0d expected %0d", n, LOAD_STALL);
        end
        idle(4);
        set_in(1, 0, 0, 0, 0, 1, 0, 1, 0);
        #1;
        advance();
        count_stalls(0, n);
        n_tests++;
        if (n != 0) begin
            n_fail++; $display("FAIL r0_no_stall: got %0d expected %0d", n, 0);
        end
    endtask

    task automatic test_branch();
        idle(4);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1);
        #1; n_tests++;
        if (outs !== 5'b11011) begin
            n_fail++; $display("FAIL br_accept: got %b expected %b", outs, 5'b11011);
        end
        advance();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1; n_tests++;
        if (outs !== 5'b00110) begin
            n_fail++; $display("FAIL br_wait_first: got %b expected %b", outs, 5'b00110);
        end
        advance();
        #1; n_tests++;
        if (outs !== 5'b10111) begin
            n_fail++; $display("FAIL br_wait_last: got %b expected %b", outs, 5'b10111);
        end
        advance();
        #1; n_tests++;
        if (outs !== 5'b11011) begin
            n_fail++; $display("FAIL br_idle_again: got %b expected %b", outs, 5'b11011);
        end
        advance();
    endtask

    task automatic test_wait();
        int n;
        idle(4);
        set_in(1, 0, 0, 0, 0, 1, 7, 1, 0);
        #1;
        advance();
        dmem_wait = 1'b1;
        set_in(1, 7, 0, 1, 0, 0, 0, 0, 0);
        repeat (4) begin
            #1; n_tests++;
            if (outs !== 5'b00100) begin
                n_fail++; $display("FAIL dmem_wait_outs: got %b expected %b", outs, 5'b00100);
            end
            advance();
        end
        dmem_wait = 1'b0;
        count_stalls(7, n);
        n_tests++;
        if (n != LOAD_STALL) begin
            n_fail++; $display("FAIL dmem_freeze_stalls: got %0d expected %0d", n, LOAD_STALL);
        end
        idle(4);
        imem_wait = 1'b1;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1; n_tests++;
        if (outs !== 5'b00001) begin
            n_fail++; $display("FAIL imem_wait_only: got %b expected %b", outs, 5'b00001);
        end
        advance();
        imem_wait = 1'b0;
    endtask

    task automatic test_enable();
        int n;
        idle(4);
        set_in(1, 0, 0, 0, 0, 1, 9, 1, 0);
        #1;
        advance();
        enable = 1'b0;
        set_in(1, 0, 9, 0, 1, 0, 0, 0, 0);
        repeat (3) begin
            #1; n_tests++;
            if (outs !== 5'b00100) begin
                n_fail++; $display("FAIL enable_low_hazard: got %b expected %b", outs, 5'b00100);
            end
            advance();
        end
        enable = 1'b1;
        count_stalls(9, n);
        n_tests++;
        if (n != LOAD_STALL) begin
            n_fail++; $display("FAIL enable_freeze_stalls: got %0d expected %0d", n, LOAD_STALL);
        end
    endtask

    task automatic test_random();
        logic [4:0] exp;
        for (int c = 0; c < 800; c++) begin
            reset     = ($urandom_range(0, 59) != 0);
            enable    = ($urandom_range(0, 9) != 0);
            dmem_wait = ($urandom_range(0, 9) == 0);
            imem_wait = ($urandom_range(0, 9) == 0);
            set_in($urandom_range(0, 4) != 0, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 6) == 0);
            #1; n_tests++;
            exp = m_out();
            if (outs !== exp) begin
                n_fail++; $display("FAIL random cycle %0d: got %b expected %b", c, outs, exp);
            end
            advance();
        end
        reset = 1'b1; enable = 1'b1; dmem_wait = 1'b0; imem_wait = 1'b0;
    endtask

    initial begin
        a_cnt = 0;
        br_end = -1;
        foreach (ready_at[i]) ready_at[i] = 0;
        reset = 1'b0; enable = 1'b1; dmem_wait = 1'b0; imem_wait = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        test_reset();
        test_data_hazard();
        test_branch();
        test_wait();
        test_enable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
